tally_bcd_counter: RTL and testbench
====================================

// Module: tally_bcd_counter
// PURPOSE
//  Consumes the slow divided clock (clkout) of the clock divider as a sample tick.
//  Debounces two active-low push-buttons (increment, clear) on that tick and keeps a
//  2-digit BCD tally (00..99), driving two static 7-segment digits and status flags.
//  Everything runs on the system clock; tick_in is treated as data, never as a clock.
// PARAMETERS
//  DEB_SAMPLES   4   consecutive equal tick samples needed to accept a key level (2..8)
//  WRAP          1   1: 99 -> 00 on increment; 0: saturate at 99
//  SEG_ACT_LOW   1   1: segment outputs active-low; 0: active-high
// PORTS
//  clk        in   1  system clock (same clock that feeds the divider)
//  rst_n      in   1  asynchronous, active-high reset (asserted = 1)
//  tick_in    in   1  divider clkout, asynchronous to logic, sampling tick source
//  key_inc_n  in   1  increment button, active-low, raw/bouncing
//  key_clr_n  in   1  clear button, active-low, raw/bouncing
//  count_bcd  out  8  {tens[3:0], ones[3:0]} BCD tally
//  seg_tens   out  7  tens digit segments {g,f,e,d,c,b,a}
//  seg_ones   out  7  ones digit segments {g,f,e,d,c,b,a}
//  inc_pulse  out  1  one-clk pulse when an accepted increment is applied
//  ovf        out  1  sticky: set on wrap (WRAP=1) or blocked increment at 99 (WRAP=0)
// BEHAVIOUR
//  - Reset (async assert, sync release): count_bcd=8'h00, ovf=0, inc_pulse=0,
//    seg_* = pattern "0" (7'b1000000 active-low / 7'b0111111 active-high),
//    tick/key synchronisers = 1... released state, debounce history all 1, stable=1.
//  - tick_in and both keys pass 2-FF synchronisers; tick = rising edge of synced
//    tick_in, one clk wide (3rd FF edge detect). tick high longer than 1 clk -> 1 tick.
//  - Per key, on each tick: shift synced key into DEB_SAMPLES-bit history. If history
//    all 0 -> stable=0; all 1 -> stable=1; mixed -> stable holds.
//  - Press event = stable 1->0 transition; one clk pulse, on the clk after the tick.
//    Release (0->1) produces no event. Held key = exactly one event.
//  - Latency: counter/flags update on the clk after the press event (press event at
//    cycle t, count_bcd/inc_pulse valid at t+1). Segments combinational from count_bcd.
//  - Increment: ones+1; ones==9 -> ones=0, tens+1. At 99: WRAP=1 -> 00, ovf<=1,
//    inc_pulse=1; WRAP=0 -> hold 99, ovf<=1, inc_pulse=0.
//  - Clear event: count_bcd<=00, ovf<=0, inc_pulse=0. Clear and increment events
//    in the same clk: clear wins, increment discarded.
//  - No tick ever arriving: keys are never sampled; count holds indefinitely.
//  - Reset mid-debounce or mid-hold: history back to all 1; key still held after
//    reset needs DEB_SAMPLES zero samples, then produces one event.
//  - BCD digits never leave 0..9; decoder maps 10..15 to blank (all segments off).
//  - Segment map (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F; SEG_ACT_LOW inverts all 7 bits.
// TESTING
//  1 Reset: rst_n=1 mid-run -> count_bcd=00, ovf=0, seg_ones=seg_tens=7'h40 (act-low).
//  2 Bounce: key_inc_n toggles every clk for 3 ticks then 0 for 4 ticks -> exactly one
//    inc_pulse, count 00->01, one clk after 4th zero-sample tick event.
//  3 Carry/wrap: 99 increments from 00 -> 99 (seg 6F^7F); 100th -> 00, ovf=1, inc_pulse=1;
//    WRAP=0 build: 100th holds 99, ovf=1, inc_pulse=0.
//  4 Clear: count 37, clear press -> 00, ovf 1->0; simultaneous clr+inc events -> 00.
//  5 Hold: key_inc_n held 0 for 50 ticks -> count +1 only; release and repress -> +1.
//  6 Tick width: tick_in high 10 clks -> single tick; tick_in stuck 0 with key 0 ->
//    count unchanged.

Source files
------------

// File: rtl/tally_bcd_counter_if.sv
// ---------------------------------------------------------------------------
// tally_bcd_counter_if : button/tick inputs and tally/segment outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tally_bcd_counter_if;
  logic       tick_in;
  logic       key_inc_n;
  logic       key_clr_n;
  logic [7:0] count_bcd;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       inc_pulse;
  logic       ovf;

  modport master (
    output tick_in,
    output key_inc_n,
    output key_clr_n,
    input  count_bcd,
    input  seg_tens,
    input  seg_ones,
    input  inc_pulse,
    input  ovf
  );

  modport slave (
    input  tick_in,
    input  key_inc_n,
    input  key_clr_n,
    output count_bcd,
    output seg_tens,
    output seg_ones,
    output inc_pulse,
    output ovf
  );
endinterface

`default_nettype wire

// File: rtl/tally_bcd_counter.sv
// ---------------------------------------------------------------------------
// tally_bcd_counter : tick-sampled key debouncer driving a 2-digit BCD tally
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tally_bcd_counter #(
  parameter int DEB_SAMPLES = 4,
  parameter bit WRAP        = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  tally_bcd_counter_if.slave    bus
);

  localparam int c_KEYS    = 2;
  localparam int c_KEY_INC = 0;
  localparam int c_KEY_CLR = 1;

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] r_rst_pipe;
  logic       w_rst;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst = r_rst_pipe[1];

  // Tick: 2-FF synchroniser plus a third stage for rising-edge detection.
  logic [2:0] r_tick_sync;
  logic       w_tick;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_tick_sync <= 3'b111;
    end else begin
      r_tick_sync <= {r_tick_sync[1:0], bus.tick_in};
    end
  end

  assign w_tick = r_tick_sync[1] & ~r_tick_sync[2];

  // Key synchronisers and tick-sampled debounce.
  logic [c_KEYS-1:0]                  w_key_raw;
  logic [c_KEYS-1:0][1:0]             r_key_sync;
  logic [c_KEYS-1:0][DEB_SAMPLES-1:0] r_hist;
  logic [c_KEYS-1:0][DEB_SAMPLES-1:0] w_hist_next;
  logic [c_KEYS-1:0]                  r_stable;
  logic [c_KEYS-1:0]                  w_stable_next;
  logic [c_KEYS-1:0]                  r_press;

  assign w_key_raw = {bus.key_clr_n, bus.key_inc_n};

  always_comb begin
    w_hist_next   = r_hist;
    w_stable_next = r_stable;
    for (int k = 0; k < c_KEYS; k++) begin
      w_hist_next[k] = {r_hist[k][DEB_SAMPLES-2:0], r_key_sync[k][1]};
      if (w_hist_next[k] == '0) begin
        w_stable_next[k] = 1'b0;
      end else if (w_hist_next[k] == '1) begin
        w_stable_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_key_sync <= '1;
      r_hist     <= '1;
      r_stable   <= '1;
      r_press    <= '0;
    end else begin
      for (int k = 0; k < c_KEYS; k++) begin
        r_key_sync[k] <= {r_key_sync[k][0], w_key_raw[k]};
      end
      if (w_tick) begin
        r_hist   <= w_hist_next;
        r_stable <= w_stable_next;
        r_press  <= r_stable & ~w_stable_next;
      end else begin
        r_press  <= '0;
      end
    end
  end

  // Tally: clear has priority over increment when both arrive together.
  logic       w_inc_evt;
  logic       w_clr_evt;
  logic [3:0] w_ones;
  logic [3:0] w_tens;
  logic [7:0] r_count;
  logic       r_ovf;
  logic       r_inc_pulse;

  assign w_inc_evt = r_press[c_KEY_INC];
  assign w_clr_evt = r_press[c_KEY_CLR];
  assign w_ones    = r_count[3:0];
  assign w_tens    = r_count[7:4];

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_count     <= 8'h00;
      r_ovf       <= 1'b0;
      r_inc_pulse <= 1'b0;
    end else if (w_clr_evt) begin
      r_count     <= 8'h00;
      r_ovf       <= 1'b0;
      r_inc_pulse <= 1'b0;
    end else if (w_inc_evt) begin
      if (r_count == 8'h99) begin
        r_ovf       <= 1'b1;
        r_inc_pulse <= WRAP;
        if (WRAP) begin
          r_count <= 8'h00;
        end
      end else if (w_ones == 4'd9) begin
        r_count     <= {w_tens + 4'd1, 4'd0};
        r_inc_pulse <= 1'b1;
      end else begin
        r_count     <= {w_tens, w_ones + 4'd1};
        r_inc_pulse <= 1'b1;
      end
    end else begin
      r_inc_pulse <= 1'b0;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return SEG_ACT_LOW ? ~pattern : pattern;
  endfunction

  assign bus.count_bcd = r_count;
  assign bus.ovf       = r_ovf;
  assign bus.inc_pulse = r_inc_pulse;
  assign bus.seg_tens  = seg7(w_tens);
  assign bus.seg_ones  = seg7(w_ones);

endmodule

`default_nettype wire

// File: tb/tb_tally_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_tally_bcd_counter : directed stimulus with a pulse scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tally_bcd_counter;

  logic clk;
  logic rst_n;
  tally_bcd_counter_if bus ();

  tally_bcd_counter #(
    .DEB_SAMPLES (4),
    .WRAP        (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  logic m_ovf    = 1'b0;
  logic mon_en   = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every inc_pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && bus.inc_pulse) begin
      if (q_exp.size() == 0) begin
        check("unexpected_inc_pulse", 32'(bus.count_bcd), 32'hFFFF);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("pulse_count", 32'(bus.count_bcd), 32'(e.cnt));
        check("pulse_ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int width);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tick_in = 1'b1;
      settle(width);
      bus.tick_in = 1'b0;
      settle(6);
    end
  endtask

  // Model of one accepted increment (WRAP=1 build).
  task automatic expect_inc();
    exp_t e;
    if (m_cnt == 99) begin
      m_cnt = 0;
      m_ovf = 1'b1;
    end else begin
      m_cnt++;
    end
    e.cnt = to_bcd(m_cnt);
    e.ovf = m_ovf;
    q_exp.push_back(e);
  endtask

  task automatic press_inc();
    expect_inc();
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(4, 2);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);
  endtask

  task automatic press_clr();
    m_cnt = 0;
    m_ovf = 1'b0;
    bus.key_clr_n = 1'b0;
    settle(3);
    ticks(4, 2);
    bus.key_clr_n = 1'b1;
    settle(3);
    ticks(4, 2);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    settle(3);
    rst_n = 1'b0;
    settle(4);
    q_exp.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_in   = 1'b0;
    bus.key_inc_n = 1'b1;
    bus.key_clr_n = 1'b1;
    rst_n         = 1'b1;
    settle(3);
    rst_n = 1'b0;
    settle(4);
    mon_en = 1'b1;

    check("reset_count", 32'(bus.count_bcd), 32'h00);
    check("reset_ovf", 32'(bus.ovf), 32'h0);
    check("reset_pulse", 32'(bus.inc_pulse), 32'h0);
    check("reset_seg_ones", 32'(bus.seg_ones), 32'h40);
    check("reset_seg_tens", 32'(bus.seg_tens), 32'h40);

    // Bouncing key for 3 ticks, then 4 clean zero samples: exactly one increment.
    expect_inc();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.key_inc_n = i[0];
      bus.tick_in   = ((i % 8) < 2);
    end
    bus.tick_in   = 1'b0;
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(4, 2);
    check("bounce_count", 32'(bus.count_bcd), 32'h01);
    check("bounce_queue", 32'(q_exp.size()), 32'd0);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);
    check("bounce_seg_ones", 32'(bus.seg_ones), 32'h79);

    // Debounce length: three zero samples are not enough, the fourth is.
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(3, 2);
    check("deb3_count", 32'(bus.count_bcd), 32'h01);
    expect_inc();
    ticks(1, 2);
    check("deb4_count", 32'(bus.count_bcd), 32'h02);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);

    // Carry through to 99, then wrap.
    while (m_cnt != 99) press_inc();
    check("count_99", 32'(bus.count_bcd), 32'h99);
    check("seg_tens_9", 32'(bus.seg_tens), 32'h10);
    check("seg_ones_9", 32'(bus.seg_ones), 32'h10);
    check("ovf_before_wrap", 32'(bus.ovf), 32'h0);
    press_inc();
    check("wrap_count", 32'(bus.count_bcd), 32'h00);
    check("wrap_ovf", 32'(bus.ovf), 32'h1);

    // Clear from 37 drops the sticky overflow.
    while (m_cnt != 37) press_inc();
    check("count_37", 32'(bus.count_bcd), 32'h37);
    check("ovf_sticky", 32'(bus.ovf), 32'h1);
    check("seg_tens_3", 32'(bus.seg_tens), 32'h30);
    check("seg_ones_7", 32'(bus.seg_ones), 32'h78);
    press_clr();
    check("clear_count", 32'(bus.count_bcd), 32'h00);
    check("clear_ovf", 32'(bus.ovf), 32'h0);

    // Simultaneous clear and increment: clear wins.
    press_inc();
    check("pre_simul_count", 32'(bus.count_bcd), 32'h01);
    bus.key_inc_n = 1'b0;
    bus.key_clr_n = 1'b0;
    m_cnt = 0;
    settle(3);
    ticks(4, 2);
    bus.key_inc_n = 1'b1;
    bus.key_clr_n = 1'b1;
    settle(3);
    ticks(4, 2);
    check("simul_count", 32'(bus.count_bcd), 32'h00);

    // Held key gives one event; release and re-press gives another.
    expect_inc();
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(50, 2);
    check("hold_count", 32'(bus.count_bcd), 32'h01);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);
    press_inc();
    check("repress_count", 32'(bus.count_bcd), 32'h02);

    // A long tick_in high is one tick: 2 short + 1 long must not complete debounce.
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(2, 2);
    ticks(1, 10);
    check("long_tick_count", 32'(bus.count_bcd), 32'h02);
    expect_inc();
    ticks(1, 2);
    check("after_long_tick", 32'(bus.count_bcd), 32'h03);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);

    // No tick at all: a pressed key is never sampled.
    bus.key_inc_n = 1'b0;
    settle(200);
    check("no_tick_count", 32'(bus.count_bcd), 32'h03);
    bus.key_inc_n = 1'b1;
    settle(3);

    // Reset mid-hold: the held key needs a full fresh debounce afterwards.
    bus.key_inc_n = 1'b0;
    settle(3);
    ticks(2, 2);
    do_reset();
    check("midhold_reset_count", 32'(bus.count_bcd), 32'h00);
    ticks(3, 2);
    check("midhold_3ticks", 32'(bus.count_bcd), 32'h00);
    expect_inc();
    ticks(1, 2);
    check("midhold_4ticks", 32'(bus.count_bcd), 32'h01);
    bus.key_inc_n = 1'b1;
    settle(3);
    ticks(4, 2);

    check("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
